mux_sel_arb: RTL and testbench
==============================

MUX_SEL_ARB -- requirements
Module: mux_sel_arb

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum ownership length in cycles, legal range 2..15; used only when ARB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 req  input  4  per-source request; bit i requests mux4 data input i.
REQ-005 done  input  1  current owner has finished; sampled only while busy=1.
REQ-006 sel  output  2  select code driving mux4 sel[1:0]; registered.
REQ-007 gnt  output  4  one-hot grant, or all-zero when idle; registered.
REQ-008 busy  output  1  high while a source owns the mux; registered.
REQ-009 tmo  output  1  one-cycle forced-release pulse; port present only when ARB_TIMEOUT_EN is defined.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE (busy=0) and OWN (busy=1).
REQ-011 Priority pointer ptr[1:0]: round-robin search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
REQ-012 IDLE, req!=0 at edge N: SHALL grant the first requester in search order; after edge N, gnt=onehot(k), sel=k, busy=1; state goes to OWN.
REQ-013 IDLE, req==0: outputs SHALL hold; sel keeps its last value so the mux output stays stable.
REQ-014 OWN: sel and gnt SHALL remain constant until a release event.
REQ-015 Release event in OWN is any of: done=1; req[sel]=0; timeout (REQ-024). Simultaneous causes SHALL count as one release.
REQ-016 On release at edge N: ptr<=sel+1 mod 4; re-arbitrate on the same edge over req with the current owner's bit masked.
REQ-017 If a winner exists in REQ-016: direct handoff; after edge N, gnt/sel show the new owner and busy stays 1, with no idle bubble.
REQ-018 If no winner exists in REQ-016 but the owner's req bit is still 1 (done or timeout cause): re-grant the same owner; busy stays 1.
REQ-019 Otherwise: gnt<=0, busy<=0, sel holds, state goes to IDLE.
REQ-020 gnt SHALL never have more than one bit set; when busy=1, gnt SHALL equal onehot(sel).
REQ-021 Latency from request to grant SHALL be exactly one cycle from IDLE.
REQ-022 A source with continuous request SHALL be granted within 4 ownership periods.

Reset
REQ-023 rst_n=0 at an edge, in any state including mid-ownership, SHALL force: sel=0, gnt=0, busy=0, ptr=0, tmo=0, timeout counter=0, state IDLE; req and done are ignored while rst_n=0.

Configuration
REQ-024 ARB_TIMEOUT_EN defined: a 4-bit counter clears on every grant or handoff and increments each OWN cycle. At the edge completing TIMEOUT cycles of ownership, the arbiter forces a release (REQ-016..019) and tmo=1 for exactly that following cycle.
REQ-025 ARB_TIMEOUT_EN undefined: no counter and no tmo port; ownership lasts until done or req drop, which may be unbounded.

Verification
REQ-026 rst_n=0 for 2 cycles, req=4'hF -> sel=0, gnt=0, busy=0 throughout; first edge with rst_n=1 -> gnt=0001, sel=0.
REQ-027 IDLE, req=4'b0100 for 1 edge -> next cycle gnt=0100, sel=2, busy=1.
REQ-028 After reset, req=4'hF held, done pulsed once per ownership -> grant order 0,1,2,3,0, with no idle cycle between grants.
REQ-029 Owner 1, req=4'b1011, done=1 -> after the edge, gnt=1000, sel=3, busy=1; with req=4'b0010, done=1 -> gnt=0010 re-granted.
REQ-030 Owner 2, req[2] drops with done=0 and no other requests -> gnt=0, busy=0, sel stays 2; mid-ownership rst_n=0 -> REQ-023 values.
REQ-031 ARB_TIMEOUT_EN, TIMEOUT=4, req=4'b0011, done=0 -> owner 0 for 4 cycles, then gnt=0010, sel=1, tmo=1 for one cycle.

Source files
------------

// File: rtl/mux_sel_arb.sv
// Round-robin owner arbiter for a 4:1 mux: registered sel/gnt/busy, direct handoff on release.
// Optional forced-release timeout is built when ARB_TIMEOUT_EN is defined (adds the tmo port).
module mux_sel_arb #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       busy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic       tmo
`endif
);

  if (TIMEOUT < 2 || TIMEOUT > 15) begin : g_timeout_range
    $error("mux_sel_arb: TIMEOUT must be within 2..15");
  end

  typedef enum logic {IDLE, OWN} state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;

  logic       timeout_hit;
  logic       release_ev;
  logic [3:0] owner_mask;
  logic [3:0] masked_req;
  logic [1:0] idle_pick;
  logic [1:0] hand_pick;

  // First set bit of r scanning p, p+1, p+2, p+3 (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

`ifdef ARB_TIMEOUT_EN
  logic [3:0] cnt_q, cnt_d;
  logic       tmo_q, tmo_d;

  // The edge that ends ownership cycle TIMEOUT sees cnt_q == TIMEOUT-1.
  assign timeout_hit = (state_q == OWN) && (cnt_q == 4'(TIMEOUT - 1));
  assign tmo         = tmo_q;
`else
  assign timeout_hit = 1'b0;
`endif

  assign owner_mask = 4'b0001 << sel_q;
  assign masked_req = req & ~owner_mask;
  assign release_ev = (state_q == OWN) && (done || !req[sel_q] || timeout_hit);
  assign idle_pick  = rr_pick(req, ptr_q);
  assign hand_pick  = rr_pick(masked_req, sel_q + 2'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      gnt_q   <= 4'd0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= 4'd0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = OWN;
      OWN:     if (release_ev && !(|masked_req) && !req[sel_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; a re-grant simply holds sel/gnt.
  always_comb begin
    ptr_d = ptr_q;
    sel_d = sel_q;
    gnt_d = gnt_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          sel_d = idle_pick;
          gnt_d = 4'b0001 << idle_pick;
        end
      end
      OWN: begin
        if (release_ev) begin
          ptr_d = sel_q + 2'd1;
          if (|masked_req) begin
            sel_d = hand_pick;
            gnt_d = 4'b0001 << hand_pick;
          end else if (!req[sel_q]) begin
            gnt_d = 4'd0;
          end
        end
      end
      default: begin
        gnt_d = 4'd0;
      end
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  always_comb begin
    tmo_d = timeout_hit;
    cnt_d = cnt_q;
    if (state_q != OWN || release_ev) cnt_d = 4'd0;
    else                               cnt_d = cnt_q + 4'd1;
  end
`endif

  assign sel  = sel_q;
  assign gnt  = gnt_q;
  assign busy = (state_q == OWN);

endmodule

// File: tb/tb_mux_sel_arb.sv
// Self-checking bench for mux_sel_arb: directed scenarios plus random traffic against a
// behavioural model of the ownership rules. Timeout checks are built with ARB_TIMEOUT_EN.
module tb_mux_sel_arb;

  localparam int TMO_LEN = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       busy;
`ifdef ARB_TIMEOUT_EN
  logic       tmo;
`endif

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit m_busy;
  int m_sel;
  int m_ptr;
  int m_cnt;
  bit m_tmo;

  mux_sel_arb #(.TIMEOUT(TMO_LEN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .done (done),
    .sel  (sel),
    .gnt  (gnt),
    .busy (busy)
`ifdef ARB_TIMEOUT_EN
    ,
    .tmo  (tmo)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int first_req(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  // One clock edge of the arbiter rules, written from the ownership description.
  function automatic void model_step(input logic rn, input logic [3:0] r, input logic d);
    logic [3:0] others;
    int         w;
    bit         expired;
    if (!rn) begin
      m_busy = 0; m_sel = 0; m_ptr = 0; m_cnt = 0; m_tmo = 0;
      return;
    end
    m_tmo = 0;
    if (!m_busy) begin
      w = first_req(r, m_ptr);
      if (w >= 0) begin
        m_busy = 1; m_sel = w; m_cnt = 0;
      end
    end else begin
      expired = TMO_EN && (m_cnt == TMO_LEN - 1);
      if (d || !r[m_sel] || expired) begin
        m_tmo  = expired;
        m_ptr  = (m_sel + 1) % 4;
        others = r;
        others[m_sel] = 1'b0;
        w = first_req(others, m_ptr);
        m_cnt = 0;
        if (w >= 0)         m_sel = w;
        else if (!r[m_sel]) m_busy = 0;
      end else begin
        m_cnt++;
      end
    end
  endfunction

  function automatic logic [6:0] model_out();
    logic [3:0] g;
    g = m_busy ? (4'b0001 << m_sel) : 4'b0000;
    return {m_busy, 2'(m_sel), g};
  endfunction

  task automatic step(input logic rn, input logic [3:0] r, input logic d);
    rst_n = rn;
    req   = r;
    done  = d;
    @(posedge clk);
    model_step(rn, r, d);
    #1;
    $display("t=%0t rst_n=%b req=%b done=%b -> busy=%b sel=%0d gnt=%b",
             $time, rn, r, d, busy, sel, gnt);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 4'hF, 1'b0);
      total++;
      if ({busy, sel, gnt} !== 7'b0_00_0000) begin
        bad++;
        $display("FAIL reset_hold[%0d] got busy=%b sel=%0d gnt=%b want 0/0/0000", i, busy, sel, gnt);
      end
    end
    step(1'b1, 4'hF, 1'b0);
    total++;
    if ({busy, sel, gnt} !== 7'b1_00_0001) begin
      bad++;
      $display("FAIL reset_first_grant got busy=%b sel=%0d gnt=%b want 1/0/0001", busy, sel, gnt);
    end
  endtask

  task automatic test_single_grant();
    step(1'b0, 4'b0000, 1'b0);
    step(1'b1, 4'b0100, 1'b0);
    total++;
    if ({busy, sel, gnt} !== 7'b1_10_0100) begin
      bad++;
      $display("FAIL single_grant got busy=%b sel=%0d gnt=%b want 1/2/0100", busy, sel, gnt);
    end
  endtask

  task automatic test_back_to_back();
    int want;
    step(1'b0, 4'hF, 1'b0);
    step(1'b1, 4'hF, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 4'hF, 1'b1);
      want = k % 4;
      total++;
      if (busy !== 1'b1 || sel !== 2'(want) || gnt !== (4'b0001 << want)) begin
        bad++;
        $display("FAIL rotation[%0d] got busy=%b sel=%0d gnt=%b want 1/%0d", k, busy, sel, gnt, want);
      end
    end
  endtask

  task automatic test_handoff();
    step(1'b0, 4'b0000, 1'b0);
    step(1'b1, 4'b0010, 1'b0);
    step(1'b1, 4'b1011, 1'b1);
    total++;
    if ({busy, sel, gnt} !== 7'b1_11_1000) begin
      bad++;
      $display("FAIL handoff got busy=%b sel=%0d gnt=%b want 1/3/1000", busy, sel, gnt);
    end
    step(1'b0, 4'b0000, 1'b0);
    step(1'b1, 4'b0010, 1'b0);
    step(1'b1, 4'b0010, 1'b1);
    total++;
    if ({busy, sel, gnt} !== 7'b1_01_0010) begin
      bad++;
      $display("FAIL regrant got busy=%b sel=%0d gnt=%b want 1/1/0010", busy, sel, gnt);
    end
  endtask

  task automatic test_drop_and_reset();
    step(1'b0, 4'b0000, 1'b0);
    step(1'b1, 4'b0100, 1'b0);
    step(1'b1, 4'b0000, 1'b0);
    total++;
    if ({busy, sel, gnt} !== 7'b0_10_0000) begin
      bad++;
      $display("FAIL req_drop got busy=%b sel=%0d gnt=%b want 0/2/0000", busy, sel, gnt);
    end
    step(1'b1, 4'b1000, 1'b0);
    step(1'b0, 4'b1000, 1'b1);
    total++;
    if ({busy, sel, gnt} !== 7'b0_00_0000) begin
      bad++;
      $display("FAIL mid_own_reset got busy=%b sel=%0d gnt=%b want 0/0/0000", busy, sel, gnt);
    end
  endtask

  task automatic test_timeout();
`ifdef ARB_TIMEOUT_EN
    step(1'b0, 4'b0000, 1'b0);
    for (int c = 1; c <= TMO_LEN; c++) begin
      step(1'b1, 4'b0011, 1'b0);
      total++;
      if ({busy, sel, gnt, tmo} !== 8'b1_00_0001_0) begin
        bad++;
        $display("FAIL tmo_own0[%0d] got busy=%b sel=%0d gnt=%b tmo=%b want 1/0/0001/0", c, busy, sel, gnt, tmo);
      end
    end
    step(1'b1, 4'b0011, 1'b0);
    total++;
    if ({busy, sel, gnt, tmo} !== 8'b1_01_0010_1) begin
      bad++;
      $display("FAIL tmo_release got busy=%b sel=%0d gnt=%b tmo=%b want 1/1/0010/1", busy, sel, gnt, tmo);
    end
    step(1'b1, 4'b0011, 1'b0);
    total++;
    if ({busy, sel, gnt, tmo} !== 8'b1_01_0010_0) begin
      bad++;
      $display("FAIL tmo_pulse_end got busy=%b sel=%0d gnt=%b tmo=%b want 1/1/0010/0", busy, sel, gnt, tmo);
    end
`endif
  endtask

  task automatic test_random();
    logic       rn;
    logic [3:0] r;
    logic       d;
    logic [6:0] exp;
    step(1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 400; i++) begin
      rn = ($urandom_range(0, 39) != 0);
      r  = 4'($urandom_range(0, 15));
      d  = ($urandom_range(0, 3) == 0);
      step(rn, r, d);
      exp = model_out();
      total++;
      if ({busy, sel, gnt} !== exp) begin
        bad++;
        $display("FAIL random[%0d] got busy=%b sel=%0d gnt=%b want busy=%b sel=%0d gnt=%b",
                 i, busy, sel, gnt, exp[6], exp[5:4], exp[3:0]);
      end
`ifdef ARB_TIMEOUT_EN
      total++;
      if (tmo !== m_tmo) begin
        bad++;
        $display("FAIL random_tmo[%0d] got tmo=%b want %b", i, tmo, m_tmo);
      end
`endif
    end
  endtask

  task automatic test_fairness();
    logic [3:0] prev_gnt;
    int         waits;
    step(1'b0, 4'b0000, 1'b0);
    prev_gnt = 4'b0000;
    waits    = 0;
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 4'($urandom_range(0, 15)) | 4'b0001, ($urandom_range(0, 1) == 1));
      if (gnt[0]) waits = 0;
      else if (gnt != prev_gnt && gnt != 4'b0000) waits++;
      prev_gnt = gnt;
      total++;
      if (waits > 3) begin
        bad++;
        $display("FAIL fairness[%0d] got %0d foreign ownerships while src0 waits want <=3", i, waits);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    test_reset();
    test_single_grant();
    test_back_to_back();
    test_handoff();
    test_drop_and_reset();
    test_timeout();
    test_random();
    test_fairness();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
